gsm_uart_tx: RTL and testbench
==============================

Name: gsm_uart_tx

Overview:
- Byte-serial UART transmitter, 8N1 by default, directly downstream of the AT-command sequencer (dialling / SMS command generators).
- Consumes the sequencer's level-style tx_enable / tx_data request and drives the serial line to the GSM modem.
- Returns a one-cycle tx_done pulse; the sequencer uses it to drop tx_enable.
- Also reports busy status so the sequencer or other masters can pace themselves.

Parameters:
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD, 9600: line rate in bit/s.
- CLKS_PER_BIT, CLK_FREQ/BAUD (5208): cycles per bit, integer-truncated; must be ≥ 2.
- STOP_BITS, 1: number of stop bits, 1 or 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- tx_enable  in  1  send request, level. A frame starts only on a 0→1 transition sampled while idle.
- tx_data  in  8  byte to send. Sampled in the start cycle only.
- txd  out  1  serial line. Idles high.
- tx_busy  out  1  high from the start cycle through the end of the last stop bit.
- tx_done  out  1  one-cycle pulse after the last stop bit completes.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): txd=1, tx_busy=0, tx_done=0, state=IDLE, counters=0, en_d=0.
  - Reset mid-frame aborts the frame; the line returns high on the next edge. No tx_done is issued.
- Edge detect: en_d is a registered copy of tx_enable. start = tx_enable & ~en_d & (state==IDLE).
- Requests are never queued:
  - A rising edge while busy is ignored.
  - tx_enable held high after tx_done does not retrigger; it must go low for ≥1 cycle, then high again.
- State machine (state, bit_cnt 0..7, baud_cnt 0..CLKS_PER_BIT-1, stop_cnt):
  - IDLE: txd=1. On start at edge k: latch tx_data into shift register, go to START, baud_cnt=0, tx_busy=1.
  - START: txd=0 from edge k+1 for exactly CLKS_PER_BIT cycles, then go to DATA with bit_cnt=0.
  - DATA: txd = shift_reg[0] (LSB first), each bit held CLKS_PER_BIT cycles. Shift right at each bit boundary. After bit 7, go to STOP.
  - STOP: txd=1 for STOP_BITS*CLKS_PER_BIT cycles, then go to DONE.
  - DONE: a single cycle. tx_done=1, tx_busy=0, txd=1, then return to IDLE.
- Latency and timing:
  - Start edge k → txd falls at k+1.
  - Frame length on the line is (1+8+STOP_BITS)*CLKS_PER_BIT cycles.
  - tx_done is high exactly at cycle k+1+(9+STOP_BITS)*CLKS_PER_BIT.
- A new start is accepted in the cycle after DONE. Back-to-back frames are therefore separated by ≥1 idle cycle plus the requester's low time.
- tx_data changing after the start cycle has no effect on the frame in flight.
- baud_cnt is wide enough for CLKS_PER_BIT-1 ($clog2). No wrap occurs inside a bit.
- txd, tx_busy and tx_done are all registered outputs; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package gsm_uart_pkg holds:
  - state enum: IDLE, START, DATA, STOP, DONE.
  - default CLK_FREQ / BAUD constants.
  - ASCII constants CR=8'h0D, LF=8'h0A.
  - The package is reused by the future modem-response receiver.
- One natural sub-module: gsm_baud_tick, a divider that emits a 1-cycle bit tick, restartable by a sync clear. The transmitter instantiates it and clears it on start.

Test Plan (CLK_FREQ=1_000_000, BAUD=100_000 → CLKS_PER_BIT=10):
- Single byte: tx_enable 0→1 with tx_data=8'h41.
  - txd low for cycles 1–10; data bits 1,0,0,0,0,0,1,0 in 10-cycle slots; high stop cycles 91–100.
  - tx_done=1 at cycle 101 only; tx_busy high cycles 0–100.
- Held enable: tx_enable kept high 300 cycles after tx_data=8'h0D.
  - Exactly one frame and one tx_done.
  - Drop for 1 cycle and raise with 8'h0A → second frame sends 8'h0A.
- Request while busy: second rising edge at cycle 40 with tx_data=8'hFF.
  - Ignored; the line carries only the first byte; one tx_done.
- Data change: tx_data switched from 8'h54 to 8'h00 at cycle 5.
  - Frame still serialises 8'h54.
- Mid-frame reset: rst=1 at cycle 50 for 1 cycle.
  - txd=1, tx_busy=0 at cycle 51; no tx_done.
  - A fresh edge afterwards sends a correct full frame.
- STOP_BITS=2, byte 8'h31:
  - Stop high for 20 cycles; tx_done at cycle 111.
  - Sequencer-style "AT\r\n" (41,54,0D,0A) decoded correctly by a bench UART model.

Source files
------------

// File: rtl/gsm_uart_pkg.sv
// Shared types and constants for the GSM modem UART link.
// Reused by the transmitter and the modem-response receiver.
package gsm_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        DONE
    } uart_state_e;

    localparam int unsigned DEF_CLK_FREQ = 50_000_000;
    localparam int unsigned DEF_BAUD     = 9600;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    function automatic int unsigned clks_per_bit(
        input int unsigned clk_freq,
        input int unsigned baud
    );
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/gsm_uart_tx_baud.sv
// Bit-period divider: one-cycle tick every CLKS_PER_BIT cycles.
// A synchronous clear realigns the bit grid to a frame start.
module gsm_baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 5208
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned W =
        (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tick_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/gsm_uart_tx.sv
// 8-bit UART transmitter for the AT-command path to the GSM modem.
// Edge-triggered request, registered line/busy/done outputs.
module gsm_uart_tx
    import gsm_uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = DEF_CLK_FREQ,
    parameter int unsigned BAUD         = DEF_BAUD,
    parameter int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD),
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_enable,
    input  logic [7:0] tx_data,
    output logic       txd,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam logic [1:0] STOP_LAST = 2'(STOP_BITS - 1);

    uart_state_e state_q;
    logic [7:0]  shift_q;
    logic [2:0]  bit_cnt_q;
    logic [1:0]  stop_cnt_q;
    logic        en_q;
    logic        txd_q;
    logic        busy_q;
    logic        done_q;

    logic start;
    logic bit_tick;

    assign start = tx_enable & ~en_q & (state_q == IDLE);

    gsm_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clr_i (start),
        .tick_o(bit_tick)
    );

    // txd follows the state one cycle later, so the line falls at k+1
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= '0;
            en_q       <= 1'b0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            en_q   <= tx_enable;
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    txd_q <= 1'b1;
                    if (start) begin
                        shift_q    <= tx_data;
                        bit_cnt_q  <= '0;
                        stop_cnt_q <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= START;
                    end
                end
                START: begin
                    txd_q <= 1'b0;
                    if (bit_tick) begin
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    txd_q <= shift_q[0];
                    if (bit_tick) begin
                        shift_q   <= {1'b0, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= STOP;
                        end
                    end
                end
                STOP: begin
                    txd_q <= 1'b1;
                    if (bit_tick) begin
                        if (stop_cnt_q == STOP_LAST) begin
                            state_q <= DONE;
                        end else begin
                            stop_cnt_q <= stop_cnt_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    txd_q   <= 1'b1;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    txd_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign txd     = txd_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_gsm_uart_tx.sv
// Bench for gsm_uart_tx: cycle-exact frame model plus a line decoder.
// Instance 0 uses one stop bit, instance 1 uses two.
module tb_gsm_uart_tx;

    logic       clk = 1'b0;
    logic       rst [2];
    logic       en  [2];
    logic [7:0] dat [2];
    logic       txd [2];
    logic       busy[2];
    logic       done[2];

    int n_checks = 0;
    int n_fail   = 0;
    int dcnt0    = 0;
    int dcnt1    = 0;
    logic [7:0] rxq0[$];
    logic [7:0] rxq1[$];

    always #5 clk = ~clk;

    gsm_uart_tx #(
        .CLK_FREQ (1_000_000),
        .BAUD     (100_000),
        .STOP_BITS(1)
    ) dut1 (
        .clk      (clk),
        .rst      (rst[0]),
        .tx_enable(en[0]),
        .tx_data  (dat[0]),
        .txd      (txd[0]),
        .tx_busy  (busy[0]),
        .tx_done  (done[0])
    );

    gsm_uart_tx #(
        .CLK_FREQ (1_000_000),
        .BAUD     (100_000),
        .STOP_BITS(2)
    ) dut2 (
        .clk      (clk),
        .rst      (rst[1]),
        .tx_enable(en[1]),
        .tx_data  (dat[1]),
        .txd      (txd[1]),
        .tx_busy  (busy[1]),
        .tx_done  (done[1])
    );

    always @(negedge clk) begin
        if (done[0] === 1'b1) dcnt0 <= dcnt0 + 1;
        if (done[1] === 1'b1) dcnt1 <= dcnt1 + 1;
    end

    // Line decoder: mid-bit sampling on the falling clock edge
    task automatic rx_byte(input int d, output logic [7:0] b, output bit ok);
        ok = 1'b1;
        b  = '0;
        repeat (4) @(negedge clk);
        if (txd[d] !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (10) @(negedge clk);
            b[i] = txd[d];
        end
        repeat (10) @(negedge clk);
        if (txd[d] !== 1'b1) ok = 1'b0;
    endtask

    always begin : rx0
        logic [7:0] rb;
        bit         rok;
        @(negedge clk);
        if (txd[0] === 1'b0) begin
            rx_byte(0, rb, rok);
            if (rok) rxq0.push_back(rb);
        end
    end

    always begin : rx1
        logic [7:0] rb;
        bit         rok;
        @(negedge clk);
        if (txd[1] === 1'b0) begin
            rx_byte(1, rb, rok);
            if (rok) rxq1.push_back(rb);
        end
    end

    // Frame model: cycle n counted from the start edge (n=0)
    function automatic logic m_txd(input int n, input logic [7:0] b);
        if (n < 1) return 1'b1;
        if (n <= 10) return 1'b0;
        if (n <= 90) return b[(n - 11) / 10];
        return 1'b1;
    endfunction

    function automatic logic m_busy(input int n, input int sb);
        return (n >= 0) && (n <= 90 + 10 * sb);
    endfunction

    function automatic logic m_done(input int n, input int sb);
        return n == 91 + 10 * sb;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rx(input int d, input logic [7:0] b);
        logic [7:0] got;
        got = 8'hxx;
        if (d == 0 && rxq0.size() != 0) got = rxq0.pop_front();
        if (d == 1 && rxq1.size() != 0) got = rxq1.pop_front();
        chk($sformatf("rx d%0d", d), 32'(got), 32'(b));
    endtask

    // ev_kind: 0 none, 1 data change, 2 re-request while busy, 3 reset
    task automatic frame(input int d, input logic [7:0] b, input bit drop,
                         input int ev_at, input int ev_kind,
                         input logic [7:0] ev_data);
        int sb;
        int last;
        sb   = (d == 0) ? 1 : 2;
        last = 91 + 10 * sb;
        en[d]  = 1'b1;
        dat[d] = b;
        for (int n = 0; n <= last + 1; n++) begin
            step();
            chk($sformatf("txd d%0d b%02h c%0d", d, b, n),
                32'(txd[d]), 32'(m_txd(n, b)));
            chk($sformatf("busy d%0d b%02h c%0d", d, b, n),
                32'(busy[d]), 32'(m_busy(n, sb)));
            chk($sformatf("done d%0d b%02h c%0d", d, b, n),
                32'(done[d]), 32'(m_done(n, sb)));
            if (drop && n == last) en[d] = 1'b0;
            if (ev_kind == 1 && n == ev_at) dat[d] = ev_data;
            if (ev_kind == 2 && n == ev_at - 10) en[d] = 1'b0;
            if (ev_kind == 2 && n == ev_at - 1) begin
                en[d]  = 1'b1;
                dat[d] = ev_data;
            end
            if (ev_kind == 3 && n == ev_at) begin
                rst[d] = 1'b1;
                en[d]  = 1'b0;
                step();
                chk("abort txd", 32'(txd[d]), 32'd1);
                chk("abort busy", 32'(busy[d]), 32'd0);
                chk("abort done", 32'(done[d]), 32'd0);
                rst[d] = 1'b0;
                return;
            end
        end
    endtask

    initial begin
        int         base;
        logic [7:0] b;
        logic [7:0] at_cmd [4];

        at_cmd = '{8'h41, 8'h54, 8'h0D, 8'h0A};
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1;
            en[d]  = 1'b0;
            dat[d] = 8'h00;
        end
        step();
        step();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset txd d%0d", d), 32'(txd[d]), 32'd1);
            chk($sformatf("reset busy d%0d", d), 32'(busy[d]), 32'd0);
            chk($sformatf("reset done d%0d", d), 32'(done[d]), 32'd0);
            rst[d] = 1'b0;
        end
        repeat (3) step();

        frame(0, 8'h41, 1'b1, 0, 0, 8'h00);
        chk_rx(0, 8'h41);

        base = dcnt0;
        frame(0, 8'h0D, 1'b0, 0, 0, 8'h00);
        repeat (300 - 93) step();
        chk("held one done", 32'(dcnt0 - base), 32'd1);
        chk("held idle busy", 32'(busy[0]), 32'd0);
        chk("held idle txd", 32'(txd[0]), 32'd1);
        en[0] = 1'b0;
        step();
        frame(0, 8'h0A, 1'b1, 0, 0, 8'h00);
        chk_rx(0, 8'h0D);
        chk_rx(0, 8'h0A);

        base = dcnt0;
        frame(0, 8'h3C, 1'b1, 40, 2, 8'hFF);
        repeat (5) step();
        chk("busy req one done", 32'(dcnt0 - base), 32'd1);
        chk_rx(0, 8'h3C);
        chk("busy req no extra rx", 32'(rxq0.size()), 32'd0);

        frame(0, 8'h54, 1'b1, 5, 1, 8'h00);
        chk_rx(0, 8'h54);

        base = dcnt0;
        frame(0, 8'hC3, 1'b1, 50, 3, 8'h00);
        repeat (60) step();
        chk("abort no done", 32'(dcnt0 - base), 32'd0);
        chk("abort idle txd", 32'(txd[0]), 32'd1);
        rxq0.delete();
        frame(0, 8'hA5, 1'b1, 0, 0, 8'h00);
        chk_rx(0, 8'hA5);

        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom);
            repeat ($urandom_range(1, 4)) step();
            frame(0, b, 1'b1, 0, 0, 8'h00);
            chk_rx(0, b);
        end

        base = dcnt1;
        frame(1, 8'h31, 1'b1, 0, 0, 8'h00);
        chk_rx(1, 8'h31);
        for (int i = 0; i < 4; i++) begin
            step();
            frame(1, at_cmd[i], 1'b1, 0, 0, 8'h00);
        end
        for (int i = 0; i < 4; i++) begin
            chk_rx(1, at_cmd[i]);
        end
        chk("stop2 done count", 32'(dcnt1 - base), 32'd5);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
